// File: rtl/bram_pkg.sv
// bram_pkg: shared defaults and credit-counter width helper for the BRAM read front end
package bram_pkg;
  localparam int BRAM_AW = 10;
  localparam int BRAM_DW = 32;
  localparam int BRAM_LATENCY = 2;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/bram_rsp_fifo.sv
// bram_rsp_fifo: synchronous response FIFO of any depth with registered storage
//   CLK, RST_L : clock, asynchronous active-low reset
//   push, din  : write din at the write pointer
//   pop        : advance the read pointer (ignored when empty)
//   count      : occupancy, head : entry at the read pointer
module bram_rsp_fifo
  import bram_pkg::*;
#(
  parameter int DW = BRAM_DW,
  parameter int DEPTH = 4,
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST_L,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [DW-1:0] head
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr, rd;
  logic do_pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign do_pop = pop && count != '0;
  assign head = mem[rd];
  always_ff @(posedge CLK or negedge RST_L)
    if (!RST_L) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push) wr <= inc(wr);
      if (do_pop) rd <= inc(rd);
      count <= count + CW'(push) - CW'(do_pop);
    end
  always_ff @(posedge CLK)
    if (push) mem[wr] <= din;
  a_no_overflow: assert property (@(posedge CLK) disable iff (!RST_L)
    !(push && !pop && count == CW'(DEPTH)));
endmodule

// File: rtl/bram_rd_ctrl.sv
// bram_rd_ctrl: BRAM read-request front end with latency pipeline and credit-protected response FIFO
//   CLK, RST_L                     : clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr   : read request handshake
//   ram_re/ram_addr/ram_dout       : fixed-latency RAM read port
//   rsp_valid/rsp_ready/rsp_data   : in-order response handshake
//   busy                           : reads in flight or responses queued
module bram_rd_ctrl
  import bram_pkg::*;
#(
  parameter int AW = BRAM_AW,
  parameter int DW = BRAM_DW,
  parameter int LATENCY = BRAM_LATENCY,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST_L,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  output logic          ram_re,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_dout,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          busy
);
  localparam int CW = cnt_w(FIFO_DEPTH);
  logic [CW-1:0] outstanding, count;
  logic [LATENCY-1:0] vpipe;
  logic fire, pop;
  // outstanding covers in-flight reads plus queued entries, so a granted request always has a FIFO slot
  always_comb begin
    req_ready = RST_L && outstanding < CW'(FIFO_DEPTH);
    fire = req_valid && req_ready;
    ram_re = fire;
    ram_addr = req_addr;
    rsp_valid = count != '0;
    pop = rsp_valid && rsp_ready;
    busy = outstanding != '0;
  end
  // shift in fire at bit0; the cast drops the old tail bit and works for LATENCY=1
  always_ff @(posedge CLK or negedge RST_L)
    if (!RST_L) begin
      vpipe <= '0;
      outstanding <= '0;
    end else begin
      vpipe <= LATENCY'({vpipe, fire});
      outstanding <= outstanding + CW'(fire) - CW'(pop);
    end
  bram_rsp_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK(CLK),
    .RST_L(RST_L),
    .push(vpipe[LATENCY-1]),
    .din(ram_dout),
    .pop(pop),
    .count(count),
    .head(rsp_data)
  );
endmodule
